// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the NCO control-frame decoder
//
// Purpose : opcode and state enums, byte-width constant, opcode validity helper.
// Ports   : none (package).
package dds_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [BYTE_W-1:0] {
    OP_FTW  = 8'h01,
    OP_POFF = 8'h02,
    OP_EN   = 8'h03
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  function automatic logic is_valid_op(input logic [BYTE_W-1:0] b);
    return (b == OP_FTW) || (b == OP_POFF) || (b == OP_EN);
  endfunction

endpackage

// File: rtl/nco_ctrl_fsm_if.sv
// rtl/nco_ctrl_fsm_if.sv - byte stream and register-load bundle of the NCO control decoder
//
// Purpose : groups the command byte handshake and the downstream register loads.
// Ports   : byte_i/byte_valid_i/byte_ready_o  command byte stream (valid/ready)
//           ftw_din_o/ftw_set_o               tuning-word data and load strobe
//           poff_din_o/poff_set_o             phase-offset data and load strobe
//           en_din_o/en_set_o                 enable data and load strobe
//           busy_o                            frame in progress
//           err_o                             one-cycle error pulse
// Modports: master = byte source / register consumer, slave = the decoder.
interface nco_ctrl_fsm_if #(
  parameter int DATA_W = 32
);
  import dds_pkg::*;

  logic [BYTE_W-1:0] byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic [DATA_W-1:0] ftw_din_o;
  logic              ftw_set_o;
  logic [DATA_W-1:0] poff_din_o;
  logic              poff_set_o;
  logic              en_din_o;
  logic              en_set_o;
  logic              busy_o;
  logic              err_o;

  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, ftw_din_o, ftw_set_o, poff_din_o, poff_set_o,
    input  en_din_o, en_set_o, busy_o, err_o
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, ftw_din_o, ftw_set_o, poff_din_o, poff_set_o,
    output en_din_o, en_set_o, busy_o, err_o
  );

endinterface

// File: rtl/nco_ctrl_timer.sv
// rtl/nco_ctrl_timer.sv - inter-byte idle counter for the NCO control decoder
//
// Purpose : counts cycles while a frame is waiting for its next byte.
// Ports   : clk, rst_n  clock / synchronous active-low reset
//           run         frame is in the data phase
//           clr         a byte was accepted this cycle
//           expired     idle count has reached TIMEOUT_CYC
module nco_ctrl_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;

  // Saturates at LIMIT so a stalled consumer of 'expired' cannot wrap it.
  always_ff @(posedge clk) begin
    if (!rst_n || !run || clr) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  assign expired = run && !clr && (cnt_q == LIMIT);

endmodule

// File: rtl/nco_ctrl_fsm.sv
// rtl/nco_ctrl_fsm.sv - command-frame decoder driving NCO tuning/phase/enable registers
//
// Purpose : parses frames of one opcode byte plus DATA_W/8 data bytes (MSB first)
//           and issues a single-cycle load strobe for the addressed register.
// Ports   : clk    rising-edge clock
//           rst_n  synchronous active-low reset
//           bus    nco_ctrl_fsm_if.slave (byte stream in, register loads out)
// Options : NCO_CTRL_TIMEOUT_EN enables the inter-byte timeout (nco_ctrl_timer).
module nco_ctrl_fsm
  import dds_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic           clk,
  input logic           rst_n,
  nco_ctrl_fsm_if.slave bus
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  if ((DATA_W % BYTE_W) != 0 || DATA_W < BYTE_W || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("nco_ctrl_fsm: illegal DATA_W or TIMEOUT_CYC");
  end

  state_t            state_q, state_d;
  opcode_t           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic accept;
  logic byte_ready;
  logic ftw_set, poff_set, en_set;
  logic tmo_expired;

  assign accept = bus.byte_valid_i && byte_ready;

`ifdef NCO_CTRL_TIMEOUT_EN
  nco_ctrl_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state_q == ST_DATA),
    .clr     (accept),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_FTW;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = 1'b0;
    byte_ready = 1'b0;
    ftw_set    = 1'b0;
    poff_set   = 1'b0;
    en_set     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        byte_ready = 1'b1;
        if (accept) begin
          if (is_valid_op(bus.byte_i)) begin
            op_d    = opcode_t'(bus.byte_i);
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_DATA: begin
        byte_ready = 1'b1;
        if (accept) begin
          // Shift MSB-first: the newest byte always lands in the low byte.
          data_d = DATA_W'({data_q, bus.byte_i});
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = ST_APPLY;
          end
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end

      ST_APPLY: begin
        // Ready is low here so data_q cannot move while the strobe is up.
        case (op_q)
          OP_FTW:  ftw_set  = 1'b1;
          OP_POFF: poff_set = 1'b1;
          OP_EN:   en_set   = 1'b1;
          default: ;
        endcase
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.byte_ready_o = byte_ready;
  assign bus.ftw_din_o    = data_q;
  assign bus.poff_din_o   = data_q;
  assign bus.en_din_o     = data_q[0];
  assign bus.ftw_set_o    = ftw_set;
  assign bus.poff_set_o   = poff_set;
  assign bus.en_set_o     = en_set;
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_nco_ctrl_fsm.sv
// tb/tb_nco_ctrl_fsm.sv - scoreboard bench for nco_ctrl_fsm
//
// Purpose : drives directed command frames and checks strobes/errors against
//           expectations queued at stimulus time. Honours NCO_CTRL_TIMEOUT_EN.
// Ports   : none (top-level bench).
module tb_nco_ctrl_fsm;

  localparam int DATA_W = 32;
  localparam int TMO    = 10;

  localparam logic [3:0] K_FTW  = 4'd1;
  localparam logic [3:0] K_POFF = 4'd2;
  localparam logic [3:0] K_EN   = 4'd3;
  localparam logic [3:0] K_ERR  = 4'd4;

  typedef struct {
    logic [3:0]  kind;
    logic [31:0] val;
    int          cyc;
    bit          chk_cyc;
  } exp_t;

  exp_t sb[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  nco_ctrl_fsm_if #(.DATA_W(DATA_W)) bus ();

  nco_ctrl_fsm #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] kind, input logic [31:0] val, input int c, input bit chk);
    exp_t e;
    e.kind = kind; e.val = val; e.cyc = c; e.chk_cyc = chk;
    sb.push_back(e);
  endtask

  // Holds valid until the byte is taken; returns the cycle of the handshake edge.
  task automatic send_byte(input logic [7:0] b, output int hs_cyc);
    bit done = 1'b0;
    hs_cyc = -1;
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.byte_ready_o === 1'b1) begin
        @(posedge clk);
        #1;
        done   = 1'b1;
        hs_cyc = cyc;
      end
    end
    if (!done) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] d,
                            input logic [3:0] kind, input logic [31:0] val);
    int h;
    send_byte(op, h);
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] w;
      w = d >> (8 * i);
      send_byte(w[7:0], h);
    end
    push(kind, val, h, 1'b1);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},     {31'd0, bus.busy_o},       32'd0);
    check({pfx, "_err"},      {31'd0, bus.err_o},        32'd0);
    check({pfx, "_ftw_set"},  {31'd0, bus.ftw_set_o},    32'd0);
    check({pfx, "_poff_set"}, {31'd0, bus.poff_set_o},   32'd0);
    check({pfx, "_en_set"},   {31'd0, bus.en_set_o},     32'd0);
    check({pfx, "_ftw_din"},  bus.ftw_din_o,             32'd0);
    check({pfx, "_poff_din"}, bus.poff_din_o,            32'd0);
    check({pfx, "_en_din"},   {31'd0, bus.en_din_o},     32'd0);
    check({pfx, "_ready"},    {31'd0, bus.byte_ready_o}, 32'd1);
  endtask

  // Output monitor: every strobe or error pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err_o === 1'b1) begin
        check("err_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("err_kind", {28'd0, K_ERR}, {28'd0, e.kind});
          if (e.chk_cyc) check("err_cycle", cyc, e.cyc);
        end
      end
      if ((bus.ftw_set_o | bus.poff_set_o | bus.en_set_o) === 1'b1) begin
        logic [3:0]  k;
        logic [31:0] v;
        check("strobe_onehot",
              32'(bus.ftw_set_o) + 32'(bus.poff_set_o) + 32'(bus.en_set_o), 32'd1);
        check("strobe_ready_low", {31'd0, bus.byte_ready_o}, 32'd0);
        check("strobe_busy", {31'd0, bus.busy_o}, 32'd1);
        if (bus.ftw_set_o)       begin k = K_FTW;  v = bus.ftw_din_o;  end
        else if (bus.poff_set_o) begin k = K_POFF; v = bus.poff_din_o; end
        else                     begin k = K_EN;   v = {31'd0, bus.en_din_o}; end
        check("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_kind", {28'd0, k}, {28'd0, e.kind});
          check("strobe_value", v, e.val);
          if (e.chk_cyc) check("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int h;
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_ready", {31'd0, bus.byte_ready_o}, 32'd1);

    // Single FTW frame, valid held high
    send_frame(8'h01, 32'h12345678, K_FTW, 32'h12345678);
    bus.byte_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back EN then POFF, no gap in valid
    send_frame(8'h03, 32'h00000001, K_EN, 32'd1);
    send_frame(8'h02, 32'h00008000, K_POFF, 32'h00008000);
    bus.byte_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Invalid opcode, then a good frame
    send_byte(8'h7F, h);
    push(K_ERR, 32'd0, h, 1'b1);
    check("inv_busy", {31'd0, bus.busy_o}, 32'd0);
    send_frame(8'h01, 32'h00000005, K_FTW, 32'h00000005);
    bus.byte_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Valid dropped for 20 cycles mid-frame
    send_byte(8'h01, h);
    send_byte(8'hAA, h);
    send_byte(8'hBB, h);
    bus.byte_valid_i = 1'b0;
`ifdef NCO_CTRL_TIMEOUT_EN
    push(K_ERR, 32'd0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("gap_busy", {31'd0, bus.busy_o}, 32'd0);
    send_frame(8'h01, 32'hCAFEF00D, K_FTW, 32'hCAFEF00D);
`else
    repeat (20) @(posedge clk);
    #1;
    check("gap_busy", {31'd0, bus.busy_o}, 32'd1);
    send_byte(8'hCC, h);
    send_byte(8'hDD, h);
    push(K_FTW, 32'hAABBCCDD, h, 1'b1);
`endif
    bus.byte_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset after two data bytes of an FTW frame
    send_byte(8'h01, h);
    send_byte(8'h12, h);
    send_byte(8'h34, h);
    bus.byte_valid_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_quiet("midrst");
    repeat (8) @(posedge clk);
    #1;
    check("midrst_busy_after", {31'd0, bus.busy_o}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
